// File: rtl/traffic_light_monitor_pkg.sv
// traffic_light_pkg: phase encoding, default durations and the legal phase order shared with the controller
package traffic_light_pkg;
  typedef enum logic [1:0] {RED = 2'b00, GREEN = 2'b01, YELLOW = 2'b10, INVALID = 2'b11} phase_t;
  typedef enum logic {UNLOCKED, LOCKED} mon_state_t;
  localparam int DEF_RED_CYCLES    = 10;
  localparam int DEF_GREEN_CYCLES  = 10;
  localparam int DEF_YELLOW_CYCLES = 5;
  function automatic phase_t next_phase(input phase_t p);
    return p == RED ? GREEN : p == GREEN ? YELLOW : p == YELLOW ? RED : INVALID;
  endfunction
endpackage

// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if: controller lamp bus (red/yellow/green)
// master drives the lamps (controller or bench), slave observes them (monitor)
interface traffic_light_monitor_if;
  logic red;
  logic yellow;
  logic green;
  modport master (output red, yellow, green);
  modport slave  (input  red, yellow, green);
endinterface

// File: rtl/traffic_light_monitor_lamp_decode.sv
// tl_lamp_decode: maps the three lamp lines to a phase and a one-hot legality flag
// ports: i_red/i_yellow/i_green lamp lines; o_phase decoded phase (don't-care when illegal); o_legal exactly one lamp lit
module tl_lamp_decode
  import traffic_light_pkg::*;
(
  input  logic   i_red,
  input  logic   i_yellow,
  input  logic   i_green,
  output phase_t o_phase,
  output logic   o_legal
);
  assign o_legal = $onehot({i_red, i_yellow, i_green});
  assign o_phase = i_red ? RED : i_green ? GREEN : YELLOW;
endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker of lamp one-hotness, phase order and per-phase dwell time
// ports: i_clk, i_rst_n (async active-low), i_clr (sync sticky-flag clear), lamps (bus slave);
//        o_locked, o_phase, o_err_onehot/o_err_order/o_err_duration (sticky), o_err (registered OR), o_cycle_cnt
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = DEF_RED_CYCLES,
  parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  parameter int DWELL_W       = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clr,
  traffic_light_monitor_if.slave  lamps,
  output logic                    o_locked,
  output logic [1:0]              o_phase,
  output logic                    o_err_onehot,
  output logic                    o_err_order,
  output logic                    o_err_duration,
  output logic                    o_err,
  output logic [7:0]              o_cycle_cnt
);
  localparam logic [DWELL_W-1:0] DWELL_MAX = {DWELL_W{1'b1}};
  mon_state_t         r_state;
  phase_t             r_phase;
  phase_t             r_last;
  logic               r_last_vld;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_err_onehot;
  logic               r_err_order;
  logic               r_err_duration;
  logic               r_err;
  logic [7:0]         r_cycle_cnt;
  phase_t             w_phase;
  logic               w_legal;
  logic               w_locked;
  logic               w_same;
  logic               w_succ;
  logic [DWELL_W-1:0] w_req;
  logic               w_set_duration;
  logic               w_set_order;
  tl_lamp_decode u_decode (
    .i_red    (lamps.red),
    .i_yellow (lamps.yellow),
    .i_green  (lamps.green),
    .o_phase  (w_phase),
    .o_legal  (w_legal)
  );
  always_comb begin
    w_locked       = r_state == LOCKED;
    w_same         = w_phase == r_phase;
    w_succ         = w_phase == next_phase(r_phase);
    w_req          = r_phase == RED   ? DWELL_W'(RED_CYCLES)   :
                     r_phase == GREEN ? DWELL_W'(GREEN_CYCLES) : DWELL_W'(YELLOW_CYCLES);
    // overstay fires on the first excess sample; early end fires on the boundary sample
    w_set_duration = w_locked && w_legal && ((w_same && r_dwell == w_req) || (w_succ && r_dwell != w_req));
    w_set_order    = w_locked && w_legal && !w_same && !w_succ;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= UNLOCKED;
      r_phase        <= INVALID;
      r_last         <= INVALID;
      r_last_vld     <= 1'b0;
      r_dwell        <= '0;
      r_err_onehot   <= 1'b0;
      r_err_order    <= 1'b0;
      r_err_duration <= 1'b0;
      r_err          <= 1'b0;
      r_cycle_cnt    <= '0;
    end else begin
      r_err_onehot   <= (r_err_onehot & ~i_clr) | ~w_legal;
      r_err_order    <= (r_err_order & ~i_clr) | w_set_order;
      r_err_duration <= (r_err_duration & ~i_clr) | w_set_duration;
      r_err          <= r_err_onehot | r_err_order | r_err_duration;
      if (w_legal) begin
        r_last     <= w_phase;
        r_last_vld <= 1'b1;
      end
      if (!w_locked) begin
        if (w_legal && r_last_vld && w_phase != r_last) begin
          r_state <= LOCKED;
          r_phase <= w_phase;
          r_dwell <= DWELL_W'(1);
        end
      end else if (!w_legal) begin
        r_state <= UNLOCKED;
        r_phase <= INVALID;
        r_dwell <= '0;
      end else if (w_same) begin
        r_dwell <= r_dwell == DWELL_MAX ? r_dwell : r_dwell + 1'b1;
      end else begin
        r_phase <= w_phase;
        r_dwell <= DWELL_W'(1);
        if (w_succ && r_phase == YELLOW) r_cycle_cnt <= r_cycle_cnt + 8'd1;
      end
    end
  end
  assign o_locked       = r_state == LOCKED;
  assign o_phase        = r_phase;
  assign o_err_onehot   = r_err_onehot;
  assign o_err_order    = r_err_order;
  assign o_err_duration = r_err_duration;
  assign o_err          = r_err;
  assign o_cycle_cnt    = r_cycle_cnt;
endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker on the `red`/`yellow`/`green` output bus of the traffic-light controller. Samples the three lamp lines each clock, decodes the current phase, and verifies one-hot encoding, phase order (RED→GREEN→YELLOW→RED) and per-phase dwell time against the controller's programmed durations. Reports sticky error flags, current phase and a completed-cycle count. Used in-system for safety monitoring and in benches as the reference checker.

## Interface
- `RED_CYCLES`, 10: required consecutive cycles with only `red` high.
- `GREEN_CYCLES`, 10: required consecutive cycles with only `green` high.
- `YELLOW_CYCLES`, 5: required consecutive cycles with only `yellow` high.
- `DWELL_W`, 5: dwell counter width; must hold max(*_CYCLES)+1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `red`, `yellow`, `green`  in  1 each  lamp lines from the controller, sampled on `clk`.
- `clr`  in  1  synchronous clear of the sticky error flags.
- `locked`  out  1  monitor is synchronised to a phase boundary.
- `phase`  out  2  current phase: RED=00, GREEN=01, YELLOW=10; 11 when unlocked.
- `err_onehot`  out  1  sticky: zero or more than one lamp high.
- `err_order`  out  1  sticky: legal lamp value but illegal successor phase.
- `err_duration`  out  1  sticky: phase ended early or overstayed.
- `err`  out  1  OR of the three sticky flags (registered).
- `cycle_cnt`  out  8  completed full cycles (YELLOW→RED transitions while locked), wraps 255→0.

## Operation
- Decode: the sampled `{red,yellow,green}` is legal only if exactly one bit is set. All other values are illegal.
- States:
  - UNLOCKED: entered at reset.
  - LOCKED: tracks phase and dwell.
- UNLOCKED:
  - Hold the last legal sample.
  - On the first change from one legal value to a different legal value, go to LOCKED, with `phase` = new value and dwell = 1.
  - No order or duration checks in this state.
  - An illegal sample sets `err_onehot`.
- LOCKED, one evaluation per rising edge:
  - Illegal sample: set `err_onehot`, go to UNLOCKED, `phase` = 11.
  - Same phase: dwell += 1, saturating at 2^DWELL_W−1. If dwell was already equal to the phase's *_CYCLES, set `err_duration` (overstay, flagged on the first excess cycle).
  - Legal successor: if dwell ≠ the phase's *_CYCLES, set `err_duration`. Then `phase` = new value and dwell = 1. On YELLOW→RED, `cycle_cnt` += 1.
  - Legal non-successor: set `err_order`, resync with `phase` = new value and dwell = 1. No duration check. `cycle_cnt` unchanged.
- Sticky flags clear only on `rst` or `clr`.
- If `clr` and a new violation occur in the same cycle, the flag ends set (set wins).
- `clr` does not affect `locked`, `phase` or `cycle_cnt`.

## Timing
- Reset values: `locked`=0, `phase`=11, all err flags 0, `err`=0, `cycle_cnt`=0, dwell=0.
- Reset is asynchronous and takes effect immediately; release is synchronous.
- All outputs are registered. A violation present in the sample at edge N is visible after edge N.
- `err` lags the individual flags by one cycle.
- `locked` rises after the edge sampling the first legal→legal change.
- Reset mid-phase: the monitor restarts UNLOCKED. The partial phase in progress is never duration-checked.
- A controller reset mid-phase is seen as RED after a non-YELLOW phase:
  - From GREEN, this sets `err_order`.
  - If the controller was already in RED, no boundary is seen. Dwell continues and an overstay is flagged.

## Structure
- Shared package `traffic_light_pkg` holds:
  - Phase encoding constants RED/GREEN/YELLOW/INVALID.
  - Default duration constants (10/10/5), shared with the controller.
  - A `next_phase` function.
- One sub-module, `tl_lamp_decode`, is combinational. It maps the three lamp lines to a 2-bit phase plus `legal`.
- The FSM, dwell counter and flags live in the top.

## Test plan
- Drive from the reference-timed controller for 3 full cycles after reset release: `locked` set at the first RED→GREEN boundary, `cycle_cnt`=2, all err flags 0.
- Shorten GREEN to 9 cycles once: `err_duration`=1 after the GREEN→YELLOW sample edge, `err`=1 one cycle later, `err_order`=0.
- Hold YELLOW for 6 cycles: `err_duration` asserts on the 6th YELLOW sample.
- Jump GREEN→RED (skip YELLOW): `err_order`=1, `phase`=00, dwell restarts, next RED→GREEN after 10 cycles gives no duration error.
- Drive `{1,0,1}` for one cycle while locked: `err_onehot`=1, `locked`=0, `phase`=11; relocks at the next legal boundary.
- Pulse `clr` simultaneously with a new overstay: flag remains 1. Pulse `clr` alone: all flags 0. Then assert `rst` mid-GREEN: all outputs return to reset values immediately.
